// File: rtl/execute_cycle_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and the
// forwarding-select codes also driven by the hazard unit.
package execute_cycle_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational RV32I ALU; undefined operation codes yield 0.
module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);
    import execute_cycle_pkg::*;

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// One cycle to the M outputs; branch redirect is combinational. No stall/flush.
module execute_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);
    import execute_cycle_pkg::*;

    logic [XLEN-1:0] src_a, write_data_e, src_b, alu_result_d;
    logic            zero_e;

    logic            regwrite_q, memwrite_q, resultsrc_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] alu_result_q, write_data_q, pcplus4_q;

    // Select 10 feeds back the registered EX/MEM result, never this cycle's ALU output.
    always_comb begin
        src_a = RD1_E;
        case (ForwardAE)
            FWD_RF:  src_a = RD1_E;
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        write_data_e = RD2_E;
        case (ForwardBE)
            FWD_RF:  write_data_e = RD2_E;
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = alu_result_q;
            default: write_data_e = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : write_data_e;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (src_a),
        .SrcB       (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result_d),
        .Zero       (zero_e)
    );

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = BranchE & zero_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            resultsrc_q  <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pcplus4_q    <= '0;
        end else begin
            regwrite_q   <= RegWriteE;
            memwrite_q   <= MemWriteE;
            resultsrc_q  <= ResultSrcE;
            rd_q         <= RD_E;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_e;
            pcplus4_q    <= PCPlus4E;
        end
    end

    assign RegWriteM  = regwrite_q;
    assign MemWriteM  = memwrite_q;
    assign ResultSrcM = resultsrc_q;
    assign RD_M       = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pcplus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Bench for execute_cycle: directed vector table, hand sequences, random vs reference model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute_cycle #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    typedef struct {
        logic        regw, memw, ressrc, alusrc, branch;
        logic [2:0]  ctl;
        logic [31:0] rd1, rd2, imm, pc, pc4, resw;
        logic [4:0]  rd;
        logic [1:0]  fa, fb;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] exp_alu, exp_wd, exp_tgt;
        logic        exp_pcsrc;
    } vec_t;

    function automatic in_t mk(logic [2:0] ctl, logic [31:0] rd1, logic [31:0] rd2);
        in_t x;
        x.regw = 1'b1; x.memw = 1'b0; x.ressrc = 1'b0; x.alusrc = 1'b0; x.branch = 1'b0;
        x.ctl = ctl; x.rd1 = rd1; x.rd2 = rd2; x.imm = 32'd0; x.pc = 32'd0;
        x.pc4 = 32'd4; x.resw = 32'd0; x.rd = 5'd3; x.fa = 2'b00; x.fb = 2'b00;
        return x;
    endfunction

    task automatic apply(input in_t x);
        RegWriteE = x.regw; MemWriteE = x.memw; ResultSrcE = x.ressrc;
        ALUSrcE = x.alusrc; BranchE = x.branch; ALUControlE = x.ctl;
        RD1_E = x.rd1; RD2_E = x.rd2; Imm_Ext_E = x.imm; PCE = x.pc;
        PCPlus4E = x.pc4; ResultW = x.resw; RD_E = x.rd;
        ForwardAE = x.fa; ForwardBE = x.fb;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: operations written straight from the ISA meaning of each code.
    function automatic logic [31:0] ref_alu(logic [2:0] ctl, logic [31:0] a, logic [31:0] b);
        case (ctl)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(logic [1:0] s, logic [31:0] rf, logic [31:0] wb, logic [31:0] mem);
        if (s == 2'b01) return wb;
        if (s == 2'b10) return mem;
        return rf;
    endfunction

    vec_t vecs[11];
    in_t  x;

    initial begin
        // ---------- directed vector table ----------
        vecs[0].in = mk(3'b000, 32'h0000_000F, 32'hFFFF_FFF0); vecs[0].exp_alu = 32'hFFFF_FFFF;
        vecs[1].in = mk(3'b001, 32'h0000_000F, 32'hFFFF_FFF0); vecs[1].exp_alu = 32'h0000_001F;
        vecs[2].in = mk(3'b010, 32'h0000_000F, 32'hFFFF_FFF0); vecs[2].exp_alu = 32'h0;
        vecs[3].in = mk(3'b011, 32'h0000_000F, 32'hFFFF_FFF0); vecs[3].exp_alu = 32'hFFFF_FFFF;
        vecs[4].in = mk(3'b101, 32'h0000_000F, 32'hFFFF_FFF0); vecs[4].exp_alu = 32'h0;
        vecs[5].in = mk(3'b111, 32'h0000_000F, 32'hFFFF_FFF0); vecs[5].exp_alu = 32'h0;
        vecs[6].in = mk(3'b100, 32'h0000_000F, 32'hFFFF_FFF0); vecs[6].exp_alu = 32'h0;
        for (int i = 0; i < 7; i++) begin
            vecs[i].exp_wd = 32'hFFFF_FFF0; vecs[i].exp_tgt = 32'h0; vecs[i].exp_pcsrc = 1'b0;
        end
        vecs[7].in = mk(3'b000, 32'h100, 32'h55);
        vecs[7].in.alusrc = 1'b1; vecs[7].in.imm = 32'hFFFF_FFFC;
        vecs[7].exp_alu = 32'hFC; vecs[7].exp_wd = 32'h55; vecs[7].exp_tgt = 32'hFFFF_FFFC; vecs[7].exp_pcsrc = 1'b0;
        vecs[8].in = mk(3'b001, 32'd9, 32'd9);
        vecs[8].in.branch = 1'b1; vecs[8].in.pc = 32'h40; vecs[8].in.imm = 32'hFFFF_FFF8; vecs[8].in.regw = 1'b0;
        vecs[8].exp_alu = 32'h0; vecs[8].exp_wd = 32'd9; vecs[8].exp_tgt = 32'h38; vecs[8].exp_pcsrc = 1'b1;
        vecs[9].in = vecs[8].in; vecs[9].in.rd2 = 32'd8;
        vecs[9].exp_alu = 32'h1; vecs[9].exp_wd = 32'd8; vecs[9].exp_tgt = 32'h38; vecs[9].exp_pcsrc = 1'b0;
        vecs[10].in = mk(3'b101, 32'hFFFF_FFF0, 32'h0000_000F);
        vecs[10].exp_alu = 32'h1; vecs[10].exp_wd = 32'h0000_000F; vecs[10].exp_tgt = 32'h0; vecs[10].exp_pcsrc = 1'b0;

        // ---------- reset then release ----------
        rst = 1'b1;
        apply(mk(3'b000, 32'd5, 32'd7));
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_alu", ALUResultM, 32'h0);
            check("rst_regw", {31'b0, RegWriteM}, 32'h0);
            check("rst_memw", {31'b0, MemWriteM}, 32'h0);
            check("rst_wd", WriteDataM, 32'h0);
            check("rst_rd_pc4", {RD_M, ResultSrcM, PCPlus4M[25:0]}, 32'h0);
        end
        rst = 1'b0;
        tick();
        check("release_alu", ALUResultM, 32'd12);
        check("release_regw", {31'b0, RegWriteM}, 32'h1);

        foreach (vecs[i]) begin
            apply(vecs[i].in);
            #1;
            check($sformatf("vec%0d_pcsrc", i), {31'b0, PCSrcE}, {31'b0, vecs[i].exp_pcsrc});
            check($sformatf("vec%0d_tgt", i), PCTargetE, vecs[i].exp_tgt);
            tick();
            check($sformatf("vec%0d_alu", i), ALUResultM, vecs[i].exp_alu);
            check($sformatf("vec%0d_wd", i), WriteDataM, vecs[i].exp_wd);
        end

        // ---------- forwarding: A from MEM, B from WB ----------
        apply(mk(3'b000, 32'h20, 32'h0));
        tick();
        check("fwd_setup", ALUResultM, 32'h20);
        x = mk(3'b000, 32'h999, 32'h777);
        x.fa = 2'b10; x.fb = 2'b01; x.resw = 32'h30;
        apply(x);
        tick();
        check("fwd_alu", ALUResultM, 32'h50);
        check("fwd_wd", WriteDataM, 32'h30);

        apply(mk(3'b000, 32'h20, 32'h0));
        tick();
        x = mk(3'b000, 32'h1, 32'h777);
        x.fa = 2'b11; x.fb = 2'b01; x.resw = 32'h30;
        apply(x);
        tick();
        check("fwd11_alu", ALUResultM, 32'h31);

        // ---------- reset mid-stream during a store ----------
        x = mk(3'b000, 32'h4, 32'h4);
        x.memw = 1'b1; x.regw = 1'b0;
        apply(x);
        tick();
        check("store_memw", {31'b0, MemWriteM}, 32'h1);
        x.ctl = 3'b001; x.branch = 1'b1;
        apply(x);
        rst = 1'b1;
        #1;
        check("rst_pcsrc_ungated", {31'b0, PCSrcE}, 32'h1);
        tick();
        check("midrst_memw", {31'b0, MemWriteM}, 32'h0);
        check("midrst_alu", ALUResultM, 32'h0);
        rst = 1'b0;

        // ---------- randomized against reference model ----------
        begin
            logic [31:0] m_alu, m_wd, m_pc4, a, wd, res;
            logic [4:0]  m_rd;
            logic        m_regw, m_memw, m_res, r;
            m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_regw = 0; m_memw = 0; m_res = 0;
            for (int it = 0; it < 400; it++) begin
                x.regw = 1'($urandom); x.memw = 1'($urandom); x.ressrc = 1'($urandom);
                x.alusrc = 1'($urandom); x.branch = 1'($urandom);
                x.ctl = 3'($urandom_range(0, 7));
                x.rd1 = $urandom; x.rd2 = ($urandom_range(0, 3) == 0) ? x.rd1 : $urandom;
                x.imm = $urandom; x.pc = $urandom; x.pc4 = $urandom; x.resw = $urandom;
                x.rd = 5'($urandom); x.fa = 2'($urandom); x.fb = 2'($urandom);
                r = (it == 0) || ($urandom_range(0, 15) == 0);
                apply(x);
                rst = r;
                a   = pick(x.fa, x.rd1, x.resw, m_alu);
                wd  = pick(x.fb, x.rd2, x.resw, m_alu);
                res = ref_alu(x.ctl, a, x.alusrc ? x.imm : wd);
                #1;
                check("rnd_pcsrc", {31'b0, PCSrcE}, {31'b0, x.branch && (res == 0)});
                check("rnd_tgt", PCTargetE, x.pc + x.imm);
                if (r) begin
                    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_regw = 0; m_memw = 0; m_res = 0;
                end else begin
                    m_alu = res; m_wd = wd; m_pc4 = x.pc4; m_rd = x.rd;
                    m_regw = x.regw; m_memw = x.memw; m_res = x.ressrc;
                end
                tick();
                check("rnd_alu", ALUResultM, m_alu);
                check("rnd_wd", WriteDataM, m_wd);
                check("rnd_pc4", PCPlus4M, m_pc4);
                check("rnd_ctl", {24'b0, RD_M, RegWriteM, MemWriteM, ResultSrcM},
                      {24'b0, m_rd, m_regw, m_memw, m_res});
            end
            rst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
